// File: rtl/ingress_rst_clk_seq_ctrl_pkg.sv
// ingress_rst_seq_pkg: sequencer states, default dwell delays and the state-to-output decode
package ingress_rst_seq_pkg;
  localparam int CNT_W = 8;
  localparam int DEF_CLK_EN_DLY = 4;
  localparam int DEF_PG_DLY = 16;
  localparam int DEF_PRI_DLY = 8;
  localparam int DEF_SEC_DLY = 8;
  localparam int DEF_DRAIN_TIMEOUT = 64;
  typedef enum logic [3:0] {
    OFF = 4'd0, CLK_ON = 4'd1, PG_REL = 4'd2, PRI_REL = 4'd3, SEC_REL = 4'd4,
    ACTIVE = 4'd5, DRAIN = 4'd6, RST_HOLD = 4'd7, ACK_WAIT = 4'd8
  } seq_state_e;
  typedef struct packed {
    logic en;
    logic pg;
    logic pri;
    logic sec;
    logic act;
    logic dreq;
    logic ack;
  } seq_out_t;
  function automatic seq_out_t decode(seq_state_e s);
    seq_out_t r;
    r.en = s != OFF;
    r.pg = s inside {OFF, CLK_ON, PG_REL};
    r.pri = s inside {OFF, CLK_ON, PG_REL, PRI_REL, RST_HOLD, ACK_WAIT};
    r.sec = !(s inside {ACTIVE, DRAIN});
    r.act = s == ACTIVE;
    r.dreq = s == DRAIN;
    r.ack = s == ACK_WAIT;
    return r;
  endfunction
endpackage

// File: rtl/ingress_rst_clk_seq_ctrl_if.sv
// ingress_rst_clk_seq_ctrl_if: platform inputs and ingress reset/enable outputs of the sequencer
interface ingress_rst_clk_seq_ctrl_if;
  logic pwr_ok;
  logic warm_rst_req;
  logic drain_done;
  logic warm_rst_ack;
  logic drain_req;
  logic enable_primary_clock;
  logic enable_secondary_clock;
  logic power_good_reset;
  logic ing_primary_reset;
  logic ing_secondary_reset;
  logic seq_active;
  logic [3:0] seq_state;
  logic drain_timeout_err;
  modport master (
    output pwr_ok, warm_rst_req, drain_done,
    input warm_rst_ack, drain_req, enable_primary_clock, enable_secondary_clock, power_good_reset,
    ing_primary_reset, ing_secondary_reset, seq_active, seq_state, drain_timeout_err
  );
  modport slave (
    input pwr_ok, warm_rst_req, drain_done,
    output warm_rst_ack, drain_req, enable_primary_clock, enable_secondary_clock, power_good_reset,
    ing_primary_reset, ing_secondary_reset, seq_active, seq_state, drain_timeout_err
  );
endinterface

// File: rtl/ingress_rst_clk_seq_ctrl_dwell_cnt.sv
// ingress_dwell_cnt: loadable down-counter; expire flags the last cycle of a dwell
module ingress_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= load ? load_val : (|cnt ? cnt - 1'b1 : cnt);
  assign expire = cnt == W'(1);
endmodule

// File: rtl/ingress_rst_clk_seq_ctrl.sv
// ingress_rst_clk_seq_ctrl: cold power-up and warm-reset/drain sequencer for the ingress block
module ingress_rst_clk_seq_ctrl
  import ingress_rst_seq_pkg::*;
#(
  parameter int CLK_EN_DLY    = DEF_CLK_EN_DLY,
  parameter int PG_DLY        = DEF_PG_DLY,
  parameter int PRI_DLY       = DEF_PRI_DLY,
  parameter int SEC_DLY       = DEF_SEC_DLY,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input logic primary_clock,
  input logic primary_reset,
  ingress_rst_clk_seq_ctrl_if.slave bus
);
  localparam int MAXV = 2 ** CNT_W - 1;
  if (CLK_EN_DLY < 1 || CLK_EN_DLY > MAXV || PG_DLY < 1 || PG_DLY > MAXV || PRI_DLY < 1 ||
      PRI_DLY > MAXV || SEC_DLY < 1 || SEC_DLY > MAXV || DRAIN_TIMEOUT < 1 || DRAIN_TIMEOUT > MAXV)
  begin : g_bad_dly
    $error("ingress_rst_clk_seq_ctrl: dwell delay outside 1..2**CNT_W-1");
  end
  seq_state_e st, nxt;
  seq_out_t so;
  logic err, err_nxt, load, expire;
  logic [CNT_W-1:0] dly;
  ingress_dwell_cnt #(.W(CNT_W)) u_cnt (
    .clk(primary_clock), .rst(primary_reset), .load(load), .load_val(dly), .expire(expire)
  );
  always_comb begin
    nxt = st;
    if (!bus.pwr_ok) nxt = OFF;
    else
      case (st)
        OFF:      nxt = CLK_ON;
        CLK_ON:   nxt = expire ? PG_REL : st;
        PG_REL:   nxt = expire ? PRI_REL : st;
        PRI_REL:  nxt = expire ? SEC_REL : st;
        SEC_REL:  nxt = expire ? ACTIVE : st;
        ACTIVE:   nxt = bus.warm_rst_req ? DRAIN : st;
        DRAIN:    nxt = (bus.drain_done || expire) ? RST_HOLD : st;
        RST_HOLD: nxt = expire ? ACK_WAIT : st;
        ACK_WAIT: nxt = bus.warm_rst_req ? st : PRI_REL;
        default:  nxt = OFF;
      endcase
  end
  // every state change reloads the shared counter with the new state's dwell
  assign load = nxt != st;
  assign dly = nxt == CLK_ON ? CNT_W'(CLK_EN_DLY) :
               nxt == PG_REL ? CNT_W'(PG_DLY) :
               (nxt == PRI_REL || nxt == RST_HOLD) ? CNT_W'(PRI_DLY) :
               nxt == SEC_REL ? CNT_W'(SEC_DLY) :
               nxt == DRAIN ? CNT_W'(DRAIN_TIMEOUT) : '0;
  assign err_nxt = err | (st == DRAIN && bus.pwr_ok && !bus.drain_done && expire);
  always_ff @(posedge primary_clock)
    if (primary_reset) begin
      st <= OFF;
      so <= decode(OFF);
      err <= 1'b0;
    end else begin
      st <= nxt;
      so <= decode(nxt);
      err <= err_nxt;
    end
  assign bus.seq_state = st;
  assign bus.enable_primary_clock = so.en;
  assign bus.enable_secondary_clock = so.en;
  assign bus.power_good_reset = so.pg;
  assign bus.ing_primary_reset = so.pri;
  assign bus.ing_secondary_reset = so.sec;
  assign bus.seq_active = so.act;
  assign bus.drain_req = so.dreq;
  assign bus.warm_rst_ack = so.ack;
  assign bus.drain_timeout_err = err;
endmodule

// File: doc/ingress_rst_clk_seq_ctrl.md
Name: ingress_rst_clk_seq_ctrl

Overview:
Sequences power-good, clock enables and the primary/secondary domain resets of the ingress block. It runs the cold power-up sequence and a warm-reset request/acknowledge flow, which includes a traffic-drain handshake with timeout. It sits between the platform power/reset sources and the ingress DUT's enable_primary_clock, enable_secondary_clock, power_good_reset, primary and secondary reset inputs.

Parameters:
CLK_EN_DLY, 4, cycles dwelt in CLK_ON before power-good release phase (min 1)
PG_DLY, 16, cycles power_good_reset stays asserted after clocks enabled (min 1)
PRI_DLY, 8, cycles primary reset held after power-good release / in warm hold (min 1)
SEC_DLY, 8, cycles secondary reset held after primary release (min 1)
DRAIN_TIMEOUT, 64, max cycles waiting for drain_done (min 1)
CNT_W, 8, dwell counter width; elaboration error if any delay > 2**CNT_W-1

Ports:
primary_clock  in  1  sole clock
primary_reset  in  1  synchronous, active-high cold reset of this controller
pwr_ok  in  1  supply stable indication
warm_rst_req  in  1  level warm-reset request
drain_done  in  1  ingress traffic drained
warm_rst_ack  out  1  warm-reset complete, held until req low
drain_req  out  1  request ingress to drain
enable_primary_clock  out  1  primary clock gate enable
enable_secondary_clock  out  1  secondary clock gate enable
power_good_reset  out  1  power-good reset to DUT, active-high
ing_primary_reset  out  1  DUT primary reset, active-high
ing_secondary_reset  out  1  DUT secondary reset, active-high
seq_active  out  1  sequence complete, DUT out of reset
seq_state  out  4  current state encoding
drain_timeout_err  out  1  sticky drain timeout flag

Behaviour:
- Clocking/reset: single clock primary_clock; primary_reset is synchronous and active-high.
- All outputs registered, Moore, decoded from next-state so they align with seq_state.
- Reset values: seq_state=OFF(0), enables=0, power_good_reset=1, ing_primary_reset=1, ing_secondary_reset=1, drain_req=0, warm_rst_ack=0, seq_active=0, drain_timeout_err=0, counter=0.
- States: OFF=0, CLK_ON=1, PG_REL=2, PRI_REL=3, SEC_REL=4, ACTIVE=5, DRAIN=6, RST_HOLD=7, ACK_WAIT=8.
- Dwell: entering a timed state loads counter with its delay; state exits on the cycle counter reaches 1. Dwell is exactly N cycles.
- OFF -> CLK_ON when pwr_ok=1. CLK_ON (C cycles) -> PG_REL (P) -> PRI_REL (R) -> SEC_REL (S) -> ACTIVE.
- Output map:
  - enables=1 in every state except OFF.
  - power_good_reset=1 in OFF/CLK_ON/PG_REL only.
  - ing_primary_reset=1 in OFF..PRI_REL, RST_HOLD, ACK_WAIT.
  - ing_secondary_reset=1 in every state except ACTIVE/DRAIN.
  - seq_active=1 in ACTIVE only; drain_req=1 in DRAIN only; warm_rst_ack=1 in ACK_WAIT only.
- Cold latency: pwr_ok sampled high at cycle t -> enables high t+1; power_good_reset low t+1+C+P; primary low t+1+C+P+R; secondary low and seq_active high t+1+C+P+R+S. Defaults: t+1, t+21, t+29, t+37.
- Warm flow:
  - ACTIVE with warm_rst_req=1 -> DRAIN, counter=DRAIN_TIMEOUT.
  - drain_done=1 -> RST_HOLD.
  - Counter expiry without drain_done -> RST_HOLD and drain_timeout_err set.
  - RST_HOLD dwells PRI_DLY, then ACK_WAIT.
  - ACK_WAIT -> PRI_REL when warm_rst_req=0.
  - power_good_reset and enables stay deasserted/asserted respectively through the warm flow.
- Boundaries:
  - pwr_ok=0 in any non-OFF state -> OFF next cycle with all reset values, except drain_timeout_err, which holds. Takes priority over all other events.
  - drain_done and timeout expiry in the same cycle -> done wins, no error.
  - warm_rst_req high outside ACTIVE is not latched; serviced when ACTIVE is reached if still high.
  - warm_rst_req dropping during DRAIN/RST_HOLD does not abort; ACK_WAIT exits immediately.
  - primary_reset at any time -> reset values next cycle, including clearing drain_timeout_err.
  - drain_done outside DRAIN is ignored.

Decomposition:
- Package ingress_rst_seq_pkg: state enum (4-bit), default delay localparams, CNT_W.
- One sub-module: ingress_dwell_cnt — load/decrement counter with expire pulse, shared by all timed states and the drain timeout.

Test Plan:
- Cold sequence, defaults: pwr_ok high at cycle 10 -> enables high at 11, power_good_reset low at 31, ing_primary_reset low at 39, ing_secondary_reset low and seq_active high at 47.
- Warm reset with drain: warm_rst_req in ACTIVE, drain_done after 5 cycles -> drain_req high for 5 cycles; resets asserted for 8 cycles; warm_rst_ack high until req low; then primary released 8 cycles and secondary a further 8 cycles later; drain_timeout_err=0.
- Drain timeout: drain_done held 0 -> drain_req high exactly 64 cycles, drain_timeout_err=1 sticky through the next ACTIVE; primary_reset clears it to 0.
- Power loss mid-sequence: pwr_ok drops in PRI_REL and in ACK_WAIT -> next cycle OFF, enables 0, all resets 1, warm_rst_ack 0; reapplied pwr_ok reruns the full 37-cycle cold sequence.
- Simultaneous drain_done and timeout expiry in the same cycle -> RST_HOLD, no error; warm_rst_req asserted during SEC_REL -> DRAIN entered the first cycle of ACTIVE.
- Synchronous primary_reset asserted in DRAIN -> all outputs return to reset values the following edge, seq_state=0.
